// File: rtl/hv_bundler.sv
// Streaming majority bundler: accumulates a burst of binary hypervectors into
// per-bit saturating signed counters and thresholds them into one class vector.
`ifndef DIM
`define DIM 1024
`endif

module hv_bundler #(
  parameter int   DIM     = `DIM,
  parameter int   CW      = 8,
  parameter int   NW      = 16,
  parameter logic TIE_BIT = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DIM-1:0] in_hv,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DIM-1:0] out_hv,
  output logic [NW-1:0]  out_count
);

  typedef enum logic {
    ACC  = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic signed [CW-1:0] CNT_MAX = {1'b0, {(CW-1){1'b1}}};
  localparam logic signed [CW-1:0] CNT_MIN = {1'b1, {(CW-1){1'b0}}};
  localparam logic signed [CW-1:0] CNT_ONE = CW'(1);

  state_t          state_reg;
  logic            out_valid_reg;
  logic [DIM-1:0]  out_hv_reg;
  logic [NW-1:0]   out_count_reg;
  logic [NW-1:0]   nvec_reg;
  logic [NW-1:0]   nvec_next;
  logic [DIM-1:0]  thr_next;
  logic            accept;
  logic            flush;

  assign in_ready  = (state_reg == ACC) && !clear;
  assign accept    = in_valid && in_ready;
  // Counters restart on abort or once the bundled vector has been taken.
  assign flush     = clear || ((state_reg == EMIT) && out_ready);
  assign nvec_next = (&nvec_reg) ? nvec_reg : nvec_reg + NW'(1);

  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : gen_bit
      logic signed [CW-1:0] cnt_reg;
      logic signed [CW-1:0] cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (in_hv[gi]) begin
          if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + CNT_ONE;
        end else begin
          if (cnt_reg != CNT_MIN) cnt_next = cnt_reg - CNT_ONE;
        end
      end

      // Threshold the post-update count so the in_last beat is included.
      assign thr_next[gi] = (cnt_next == '0) ? TIE_BIT : ~cnt_next[CW-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (flush) begin
          cnt_reg <= '0;
        end else if (accept) begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ACC;
      nvec_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_hv_reg    <= '0;
      out_count_reg <= '0;
    end else if (clear) begin
      state_reg     <= ACC;
      nvec_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_hv_reg    <= '0;
      out_count_reg <= '0;
    end else begin
      case (state_reg)
        ACC: begin
          if (accept) begin
            nvec_reg <= nvec_next;
            if (in_last) begin
              state_reg     <= EMIT;
              out_valid_reg <= 1'b1;
              out_hv_reg    <= thr_next;
              out_count_reg <= nvec_next;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            state_reg     <= ACC;
            out_valid_reg <= 1'b0;
            nvec_reg      <= '0;
          end
        end
        default: state_reg <= ACC;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_hv    = out_hv_reg;
  assign out_count = out_count_reg;

endmodule

// File: doc/hv_bundler.md
# hv_bundler

Streaming majority bundler for the HDC datapath. It accumulates a burst of binary hypervectors into per-bit saturating signed counters, then thresholds them into one bundled class hypervector. It sits on the write side of class memory. Its outputs are the stored prototypes that the Hamming-distance similarity unit later compares against query vectors.

## Interface
Parameters:
- `DIM`, default `` `DIM `` (1024): hypervector width in bits.
- `CW`, default 8: width of each per-bit signed counter.
- `NW`, default 16: width of the bundled-vector count.
- `TIE_BIT`, default 1'b0: output bit value when a counter is exactly 0.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `clear`, input, 1: synchronous abort and restart.
- `in_valid`, input, 1: input hypervector valid.
- `in_ready`, output, 1: bundler accepts an input beat.
- `in_hv`, input, `DIM`: input hypervector.
- `in_last`, input, 1: marks the final vector of the bundle.
- `out_valid`, output, 1: bundled vector available.
- `out_ready`, input, 1: consumer accepts the bundled vector.
- `out_hv`, output, `DIM`: bundled hypervector, registered.
- `out_count`, output, `NW`: number of vectors in the bundle, registered.

## Operation
- The FSM has two states, ACC and EMIT. Reset state is ACC.
- `in_ready` = (state == ACC) && !`clear`. It is combinational from the state register.
- An input beat is accepted when `in_valid` && `in_ready`. On each beat, for every bit i:
  - `cnt[i]` += 1 if `in_hv[i]` is 1, else `cnt[i]` -= 1.
  - The result saturates at +(2^(CW-1)-1) and -(2^(CW-1)).
- `nvec` increments on every accepted beat and saturates at 2^NW-1.
- Accepted beat with `in_last` = 1:
  - The same beat is still accumulated.
  - The next state is EMIT.
  - `out_hv[i]` is registered from the updated counter: 1 if `cnt` > 0, 0 if `cnt` < 0, `TIE_BIT` if `cnt` == 0.
  - `out_count` is registered as the updated `nvec`.
- In EMIT:
  - `out_valid` = 1. `out_hv` and `out_count` hold stable until the handshake.
  - `in_valid` is ignored.
  - When `out_valid` && `out_ready`: all counters and `nvec` return to 0, `out_valid` drops, and the next state is ACC.
- `clear` has priority over everything in any state:
  - Counters and `nvec` return to 0, `out_valid` goes to 0, and the next state is ACC.
  - A beat presented in the same cycle is dropped (`in_ready` is already low).
  - A pending output is discarded.
- There is no first-beat special case. A bundle of one vector reproduces that vector exactly.

## Timing
- Reset (`rst_n` low) asynchronously forces:
  - state = ACC, all `cnt` = 0, `nvec` = 0;
  - `out_valid` = 0, `out_hv` = 0, `out_count` = 0.
  - `in_ready` therefore reads 1 unless `clear` is asserted.
- Reset mid-bundle or mid-EMIT loses all partial state. There is no recovery.
- Throughput: one input vector per cycle in ACC.
- Latency: `out_valid` rises the cycle after the `in_last` beat is accepted.
- Minimum dead time: one cycle per bundle. After the output handshake, `in_ready` is 1 on the following cycle.
- `out_hv` and `out_count` change only on the `in_last` beat, on `clear`, or on reset.
- The output interface follows the standard valid/ready rule: once `out_valid` is raised, it stays high with stable data until `out_ready` or `clear`.

## Test plan
Directed scenarios use `DIM`=8, `CW`=4, `TIE_BIT`=0.
- Single beat 8'hA5 with `in_last` -> next cycle `out_valid`=1, `out_hv`=8'hA5, `out_count`=1.
- Beats 8'hF0, 8'hCC, then 8'hAA with `in_last` -> `out_hv`=8'hE8 (bitwise majority), `out_count`=3.
- Tie case: 8'hFF then 8'h00 with `in_last` -> `out_hv`=8'h00, `out_count`=2. Repeat with `TIE_BIT`=1 -> 8'hFF.
- Saturation: ten beats of 8'hFF, then seven beats of 8'h00 (last one with `in_last`). Counters saturate at +7 and then reach 0 -> `out_hv`=8'h00, `out_count`=17. Without saturation the result would be 8'hFF.
- Backpressure: hold `out_ready` low for 5 cycles in EMIT while driving `in_valid` -> `out_valid` stays 1, `out_hv` is stable, `in_ready`=0, no beats are counted. After `out_ready`, the next bundle of 8'h3C yields 8'h3C with count 1.
- Abort paths:
  - `clear` together with `in_valid` mid-bundle -> beat dropped, next bundle of 8'h81 yields 8'h81 with count 1.
  - `clear` in EMIT -> `out_valid` drops the next cycle.
  - `rst_n` pulsed mid-bundle -> all outputs 0 immediately, and a fresh bundle is correct.
